mc_ctrl: RTL

- Multi-cycle sequencer for the MIPS datapath: add, sub, ori, lw, sw, beq, lui, jal, jr, sll and nop (nop is sll with all fields zero).
- One instruction at a time steps through IDLE/FETCH/DECODE/EXEC/MEM/WB.
- A single shared memory port serves both instruction fetch and data access, using a req/ready handshake.
- The block decodes the held instruction register (IR) and drives the PC, IR, GRF, ALU and memory enables and selects.

---
 rtl/mc_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl : multi-cycle MIPS sequencer driving the PC/IR/GRF/ALU/memory selects
// Revision: 1.0
// ---------------------------------------------------------------------------
module mc_ctrl #(
   parameter int unsigned RA_IDX = 31
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        alu_zero,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_write,
   output logic        pc_write,
   output logic [2:0]  next_pc_op,
   output logic        reg_write,
   output logic        a1_op,
   output logic [1:0]  reg_addr_op,
   output logic [2:0]  reg_data_op,
   output logic [2:0]  alu_op,
   output logic [2:0]  alu_b_sel,
   output logic        retire,
   output logic        illegal,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic [5:0] w_opc;
   logic [5:0] w_fn;
   logic       w_rtype;
   logic       w_add, w_sub, w_sll, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_jal;
   logic       w_legal;

   // Register-field bits and RA_IDX are consumed by the datapath, not here.
   logic       w_unused;
   assign w_unused = ^{instr[25:6], 5'(RA_IDX)};

   assign w_opc   = instr[31:26];
   assign w_fn    = instr[5:0];
   assign w_rtype = (w_opc == 6'h00);
   assign w_add   = w_rtype && (w_fn == 6'h20);
   assign w_sub   = w_rtype && (w_fn == 6'h22);
   assign w_sll   = w_rtype && (w_fn == 6'h00);
   assign w_jr    = w_rtype && (w_fn == 6'h08);
   assign w_ori   = (w_opc == 6'h0D);
   assign w_lw    = (w_opc == 6'h23);
   assign w_sw    = (w_opc == 6'h2B);
   assign w_beq   = (w_opc == 6'h04);
   assign w_lui   = (w_opc == 6'h0F);
   assign w_jal   = (w_opc == 6'h03);
   assign w_legal = w_add | w_sub | w_sll | w_jr | w_ori | w_lw | w_sw |
                    w_beq | w_lui | w_jal;

   logic       w_req, w_we, w_asel, w_irw, w_pcw, w_rw, w_a1, w_ret, w_ill;
   logic [2:0] w_npc, w_rdo, w_aop, w_bsel;
   logic [1:0] w_rao;

   always_comb begin
      state_d = state_q;
      w_req   = 1'b0;
      w_we    = 1'b0;
      w_asel  = 1'b0;
      w_irw   = 1'b0;
      w_pcw   = 1'b0;
      w_npc   = 3'd0;
      w_rw    = 1'b0;
      w_a1    = 1'b0;
      w_rao   = 2'd0;
      w_rdo   = 3'd0;
      w_aop   = 3'd0;
      w_bsel  = 3'd0;
      w_ret   = 1'b0;
      w_ill   = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            w_req = 1'b1;
            if (mem_ready) begin
               w_irw   = 1'b1;
               w_pcw   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!w_legal) begin
               w_ill   = 1'b1;
               state_d = S_FETCH;
            end else if (w_lui || w_jal) begin
               state_d = S_WB;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_WB;
            if (w_sub) w_aop = 3'd1;
            if (w_ori) begin
               w_aop  = 3'd2;
               w_bsel = 3'd2;
            end
            if (w_lw || w_sw) begin
               w_bsel  = 3'd1;
               state_d = S_MEM;
            end
            if (w_sll) begin
               w_bsel = 3'd3;
               w_a1   = 1'b1;
            end
            if (w_beq) begin
               w_aop   = 3'd3;
               w_pcw   = alu_zero;
               w_npc   = 3'd1;
               w_ret   = 1'b1;
               state_d = S_FETCH;
            end
            if (w_jr) begin
               w_pcw   = 1'b1;
               w_npc   = 3'd3;
               w_ret   = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            w_req  = 1'b1;
            w_asel = 1'b1;
            w_we   = w_sw;
            if (mem_ready) begin
               w_ret   = w_sw;
               state_d = w_sw ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            w_rw    = 1'b1;
            w_ret   = 1'b1;
            state_d = S_FETCH;
            if (w_lw) begin
               w_rao = 2'd1;
               w_rdo = 3'd1;
            end
            if (w_lui) begin
               w_rao = 2'd1;
               w_rdo = 3'd2;
            end
            // Link writes the already-advanced PC while the jump target loads.
            if (w_jal) begin
               w_rao = 2'd2;
               w_rdo = 3'd3;
               w_pcw = 1'b1;
               w_npc = 3'd2;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Strobes are squashed while reset is held so no write escapes mid-instruction.
   assign mem_req      = reset_n & w_req;
   assign mem_we       = reset_n & w_we;
   assign ir_write     = reset_n & w_irw;
   assign pc_write     = reset_n & w_pcw;
   assign reg_write    = reset_n & w_rw;
   assign retire       = reset_n & w_ret;
   assign illegal      = reset_n & w_ill;
   assign mem_addr_sel = w_asel;
   assign next_pc_op   = w_npc;
   assign a1_op        = w_a1;
   assign reg_addr_op  = w_rao;
   assign reg_data_op  = w_rdo;
   assign alu_op       = w_aop;
   assign alu_b_sel    = w_bsel;
   assign state        = state_q;

endmodule
`default_nettype wire
